// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the architectural data width.
package mips_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/md_datapath.sv
// Iteration datapath: LSB-first shift-add multiplier and MSB-first restoring
// divider sharing one 2*WIDTH accumulator. Operates on unsigned magnitudes.
module md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               load_div,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    // Multiply keeps the multiplier in the low half and shifts the product in
    // from the top; divide keeps the dividend/quotient in the low half.
    always_comb begin
        acc_d   = acc_q;
        rem_d   = rem_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        shifted = {rem_q, acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        if (load) begin
            acc_d  = {{WIDTH{1'b0}}, (load_div ? a_mag : b_mag)};
            opnd_d = load_div ? b_mag : a_mag;
            rem_d  = '0;
            div_d  = load_div;
        end else if (step) begin
            if (div_q) begin
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            rem_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rem_q  <= rem_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
        end
    end

    assign prod = acc_q;
    assign quot = acc_q[WIDTH-1:0];
    assign rem  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Control FSM, iteration counter, sign handling and HI/LO writes live here.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mips_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               load;
    logic               step;
    logic               signed_op;
    logic signed [WIDTH-1:0] rs_s;
    logic signed [WIDTH-1:0] rt_s;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign rs_s      = rs_data;
    assign rt_s      = rt_data;
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op && (rs_s < 0);
    assign b_neg     = signed_op && (rt_s < 0);
    assign a_mag     = cond_neg(rs_data, a_neg);
    assign b_mag     = cond_neg(rt_data, b_neg);

    md_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step     (step),
        .load_div (op[1]),
        .a_mag    (a_mag),
        .b_mag    (b_mag),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = op[1] && a_neg;
                    dz_d      = op[1] && (rt_data == '0);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                // Divide-by-zero quotient is forced; the remainder path already
                // reproduces the dividend because every trial subtract succeeds.
                if (is_div_q) begin
                    lo_d = dz_q ? '1 : cond_neg(quot, neg_res_q);
                    hi_d = cond_neg(rem, neg_rem_q);
                end else begin
                    {hi_d, lo_d} = cond_neg_wide(prod, neg_res_q);
                end
                cnt_d   = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases, randomized ops
// against an arithmetic reference model, and control-path scenarios.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct packed {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t vecs [10] = '{
        '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
        '{2'b00, 32'hFFFFFFFA, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFD6},
        '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
        '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
        '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
        '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF},
        '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
        '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
        '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9},
        '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}
    };

    // Reference result {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {32'(r), 32'(q)};
                end
            end
            default: begin
                if (b == 32'h0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h00000000;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h00000001;
            4: v = 32'($urandom_range(1, 100));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Leaves the bench at the falling edge right after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (!done && lat < 60) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        rs_data = '0;
        rt_data = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wr_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags: busy/done got %b expected 00", {busy, done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed();
        int lat;
        int bn;
        foreach (vecs[i]) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b);
            wait_done(lat, bn);
            checks++;
            if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
            checks++;
            if (bn != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", i, bn); end
            checks++;
            if (hi !== vecs[i].h) begin errors++; $display("FAIL dir%0d_hi: got %h expected %h", i, hi, vecs[i].h); end
            checks++;
            if (lo !== vecs[i].l) begin errors++; $display("FAIL dir%0d_lo: got %h expected %h", i, lo, vecs[i].l); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, busy); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b expected 0", i, done); end
        end
    endtask

    task automatic test_random();
        int lat;
        int bn;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom);
            a = pick_operand();
            b = pick_operand();
            exp = model(o, a, b);
            issue(o, a, b);
            wait_done(lat, bn);
            checks++;
            if (lat != 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 33", n, lat); end
            checks++;
            if ({hi, lo} !== exp) begin
                errors++;
                $display("FAIL rnd%0d_result: op=%0d a=%h b=%h got %h expected %h", n, o, a, b, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_ignore_while_busy();
        int lat;
        int bn;
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        wr_data = 32'h5A5A1234;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        issue(2'b01, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        rs_data = 32'd9;
        rt_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        mthi = 1'b1;
        wr_data = 32'hDEADBEEF;
        @(negedge clk);
        mthi = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h5A5A1234, 32'h5A5A1234}) begin
            errors++;
            $display("FAIL busy_hold: got %h expected %h", {hi, lo}, {32'h5A5A1234, 32'h5A5A1234});
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b expected 1", busy); end
        wait_done(lat, bn);
        checks++;
        if (lat != 20) begin errors++; $display("FAIL busy_latency: got %0d expected 20", lat); end
        checks++;
        if ({hi, lo} !== {32'h0, 32'd15}) begin errors++; $display("FAIL busy_result: got %h expected %h", {hi, lo}, {32'h0, 32'd15}); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL busy_no_relaunch: busy/done got %b expected 00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        a = $urandom;
        b = $urandom;
        exp = model(2'b01, a, b);
        issue(2'b01, a, b);
        wait_done(lat, bn);
        checks++;
        if ({hi, lo} !== exp) begin errors++; $display("FAIL b2b_first: got %h expected %h", {hi, lo}, exp); end
        start = 1'b1;
        op = 2'b11;
        rs_data = 32'd1000;
        rt_data = 32'd7;
        @(negedge clk);
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        checks++;
        if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_accept: busy/done got %b expected 10", {busy, done}); end
        wait_done(lat, bn);
        checks++;
        if (lat != 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        checks++;
        if ({hi, lo} !== {32'd6, 32'd142}) begin errors++; $display("FAIL b2b_second: got %h expected %h", {hi, lo}, {32'd6, 32'd142}); end
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        int bn;
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        wr_data = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'h12345678, 32'h12345678}) begin errors++; $display("FAIL mt_both: got %h expected %h", {hi, lo}, {32'h12345678, 32'h12345678}); end
        mthi = 1'b1;
        wr_data = 32'hCAFEF00D;
        @(negedge clk);
        mthi = 1'b0;
        checks++;
        if ({hi, lo} !== {32'hCAFEF00D, 32'h12345678}) begin errors++; $display("FAIL mt_hi_only: got %h expected %h", {hi, lo}, {32'hCAFEF00D, 32'h12345678}); end
        mtlo = 1'b1;
        wr_data = 32'h0BADF00D;
        @(negedge clk);
        mtlo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'hCAFEF00D, 32'h0BADF00D}) begin errors++; $display("FAIL mt_lo_only: got %h expected %h", {hi, lo}, {32'hCAFEF00D, 32'h0BADF00D}); end
        mthi = 1'b1;
        mtlo = 1'b1;
        wr_data = 32'hFFFF0000;
        start = 1'b1;
        op = 2'b01;
        rs_data = 32'd2;
        rt_data = 32'd2;
        @(negedge clk);
        start = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        checks++;
        if ({hi, lo} !== {32'hCAFEF00D, 32'h0BADF00D}) begin errors++; $display("FAIL mt_with_start: got %h expected %h", {hi, lo}, {32'hCAFEF00D, 32'h0BADF00D}); end
        wait_done(lat, bn);
        checks++;
        if ({hi, lo} !== {32'h0, 32'd4}) begin errors++; $display("FAIL mt_start_result: got %h expected %h", {hi, lo}, {32'h0, 32'd4}); end
    endtask

    task automatic test_async_reset();
        logic saw_done;
        @(negedge clk);
        mthi = 1'b1;
        mtlo = 1'b1;
        wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        issue(2'b11, 32'd12345, 32'd17);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL arst_hilo: got %h expected 0", {hi, lo}); end
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL arst_flags: busy/done got %b expected 00", {busy, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL arst_no_done: got %b expected 0", saw_done); end
        checks++;
        if ({busy, hi, lo} !== 65'h0) begin errors++; $display("FAIL arst_after: got %h expected 0", {busy, hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_while_busy();
        test_back_to_back();
        test_mthi_mtlo();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
